// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite arbitration definitions.
// Contents: FSM state encodings, master identifiers and the OKAY response code.
package axi_lite_pkg;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RD   = 2'd1;
    localparam state_t WR   = 2'd2;

    // Master identifiers
    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    // Response code
    localparam logic RESP_OKAY = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
// Ports:
//   req_i       - request vector, bit n is master n
//   last_i      - id of the master granted most recently
//   en_i        - arbitration enable; no grant when low
//   gnt_id_o    - id of the winning master
//   gnt_valid_o - a grant is being issued this cycle
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       en_i,
    output logic       gnt_id_o,
    output logic       gnt_valid_o
);

    // On a tie the master that did not win last time gets the grant
    always_comb begin
        gnt_valid_o = en_i & (|req_i);
        gnt_id_o    = 1'b0;
        if (req_i == 2'b11) begin
            gnt_id_o = ~last_i;
        end else if (req_i[1]) begin
            gnt_id_o = 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter2.sv
// Two-master to one-slave AXI-lite arbiter. One transaction in flight at a time.
// Master 0 is the instruction fetch unit, master 1 the load/store unit.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   m{0,1}_ar*/r*      - read address / read data channels of each master
//   m{0,1}_aw*/w*/b*   - write address / data / response channels of each master
//   s_*                - slave-side channels towards the shared memory
module axi_lite_arbiter2
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_W-1:0]     m0_awaddr,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    output logic                  m0_bresp,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    // master 1
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic                  m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    // slave
    output logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic                  s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic                  s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready
);

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic [1:0] req_c;
    logic       gnt_id_c;
    logic       gnt_valid_c;
    logic       rd_act_c;
    logic       wr_act_c;

    // Owner-selected request side
    logic [ADDR_W-1:0]   own_araddr_c;
    logic                own_arvalid_c;
    logic                own_rready_c;
    logic [ADDR_W-1:0]   own_awaddr_c;
    logic                own_awvalid_c;
    logic [DATA_W-1:0]   own_wdata_c;
    logic [DATA_W/8-1:0] own_wstrb_c;
    logic                own_wvalid_c;
    logic                own_bready_c;

    logic ar_hs_c;
    logic aw_hs_c;
    logic w_hs_c;
    logic r_hs_c;
    logic b_hs_c;

    assign req_c[0] = m0_arvalid | m0_awvalid | m0_wvalid;
    assign req_c[1] = m1_arvalid | m1_awvalid | m1_wvalid;

    rr_arb2 u_rr_arb2 (
        .req_i       (req_c),
        .last_i      (last_q),
        .en_i        ((state_q == IDLE) & ~rst),
        .gnt_id_o    (gnt_id_c),
        .gnt_valid_o (gnt_valid_c)
    );

    // Outputs are held at zero throughout the reset cycle, whatever the state
    assign rd_act_c = ~rst & (state_q == RD);
    assign wr_act_c = ~rst & (state_q == WR);

    assign own_araddr_c  = (owner_q == M_LSU) ? m1_araddr  : m0_araddr;
    assign own_arvalid_c = (owner_q == M_LSU) ? m1_arvalid : m0_arvalid;
    assign own_rready_c  = (owner_q == M_LSU) ? m1_rready  : m0_rready;
    assign own_awaddr_c  = (owner_q == M_LSU) ? m1_awaddr  : m0_awaddr;
    assign own_awvalid_c = (owner_q == M_LSU) ? m1_awvalid : m0_awvalid;
    assign own_wdata_c   = (owner_q == M_LSU) ? m1_wdata   : m0_wdata;
    assign own_wstrb_c   = (owner_q == M_LSU) ? m1_wstrb   : m0_wstrb;
    assign own_wvalid_c  = (owner_q == M_LSU) ? m1_wvalid  : m0_wvalid;
    assign own_bready_c  = (owner_q == M_LSU) ? m1_bready  : m0_bready;

    // Channel handshakes; done flags block re-issuing an already accepted beat
    assign ar_hs_c = rd_act_c & own_arvalid_c & ~ar_done_q & s_arready;
    assign r_hs_c  = rd_act_c & s_rvalid & own_rready_c;
    assign aw_hs_c = wr_act_c & own_awvalid_c & ~aw_done_q & s_awready;
    assign w_hs_c  = wr_act_c & own_wvalid_c & ~w_done_q & s_wready;
    assign b_hs_c  = wr_act_c & s_bvalid & own_bready_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= M_IFU;
            last_q    <= M_LSU;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid_c) begin
                    owner_d   = gnt_id_c;
                    last_d    = gnt_id_c;
                    ar_done_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    // A master presenting both a read and a write is served read first
                    if ((gnt_id_c == M_LSU) ? m1_arvalid : m0_arvalid) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD: begin
                if (ar_hs_c) begin
                    ar_done_d = 1'b1;
                end
                if (r_hs_c) begin
                    state_d = IDLE;
                end
            end
            WR: begin
                if (aw_hs_c) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs_c) begin
                    w_done_d = 1'b1;
                end
                if (b_hs_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational routing between the owner and the slave; everything else stays 0
    always_comb begin
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = RESP_OKAY;
        m0_rvalid  = 1'b0;
        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m0_bresp   = RESP_OKAY;
        m0_bvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = RESP_OKAY;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = RESP_OKAY;
        m1_bvalid  = 1'b0;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;

        if (rd_act_c) begin
            s_araddr  = own_araddr_c;
            s_arvalid = own_arvalid_c & ~ar_done_q;
            s_rready  = own_rready_c;
            if (owner_q == M_LSU) begin
                m1_arready = s_arready & ~ar_done_q;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
            end else begin
                m0_arready = s_arready & ~ar_done_q;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
            end
        end

        if (wr_act_c) begin
            s_awaddr  = own_awaddr_c;
            s_awvalid = own_awvalid_c & ~aw_done_q;
            s_wdata   = own_wdata_c;
            s_wstrb   = own_wstrb_c;
            s_wvalid  = own_wvalid_c & ~w_done_q;
            s_bready  = own_bready_c;
            if (owner_q == M_LSU) begin
                m1_awready = s_awready & ~aw_done_q;
                m1_wready  = s_wready & ~w_done_q;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
            end else begin
                m0_awready = s_awready & ~aw_done_q;
                m0_wready  = s_wready & ~w_done_q;
                m0_bresp   = s_bresp;
                m0_bvalid  = s_bvalid;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter2.sv
// Directed bench for axi_lite_arbiter2 with a behavioural always-ready memory slave.
module tb_axi_lite_arbiter2;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] m0_araddr = '0, m1_araddr = '0;
    logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
    logic        m0_arready, m1_arready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_rresp, m1_rresp, m0_rvalid, m1_rvalid;
    logic        m0_rready = 1'b0, m1_rready = 1'b0;
    logic [31:0] m0_awaddr = '0, m1_awaddr = '0;
    logic        m0_awvalid = 1'b0, m1_awvalid = 1'b0;
    logic        m0_awready, m1_awready;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_wvalid = 1'b0, m1_wvalid = 1'b0;
    logic        m0_wready, m1_wready;
    logic        m0_bresp, m1_bresp, m0_bvalid, m1_bvalid;
    logic        m0_bready = 1'b0, m1_bready = 1'b0;

    logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic        s_arready, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid;

    int n_cmp  = 0;
    int n_fail = 0;
    int ar_base;

    always #5 clk = ~clk;

    axi_lite_arbiter2 #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    // OR of every DUT output, used for the all-outputs-zero checks
    logic any_out;
    assign any_out = |{m0_arready, m0_rdata, m0_rresp, m0_rvalid, m0_awready, m0_wready,
                       m0_bresp, m0_bvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid,
                       m1_awready, m1_wready, m1_bresp, m1_bvalid, s_araddr, s_arvalid,
                       s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready};

    // Memory slave: always-ready ar/aw/w, read data one cycle after ar, single-cycle bvalid
    logic [31:0] mem [0:255];
    logic        sl_rvalid_q = 1'b0;
    logic [31:0] sl_rdata_q  = '0;
    logic        sl_bvalid_q = 1'b0;
    logic        sl_aw_got   = 1'b0;
    logic        sl_w_got    = 1'b0;
    logic [7:0]  sl_awidx    = '0;
    logic [31:0] sl_wdata    = '0;
    logic [3:0]  sl_wstrb    = '0;
    int          ar_hs_cnt   = 0;

    assign s_arready = 1'b1;
    assign s_awready = 1'b1;
    assign s_wready  = 1'b1;
    assign s_rresp   = 1'b0;
    assign s_bresp   = 1'b0;
    assign s_rvalid  = sl_rvalid_q;
    assign s_rdata   = sl_rdata_q;
    assign s_bvalid  = sl_bvalid_q;

    always @(posedge clk) begin
        logic        aw_now, w_now;
        logic [7:0]  idx;
        logic [31:0] wd;
        logic [3:0]  ws;
        if (s_arvalid) begin
            sl_rvalid_q <= 1'b1;
            sl_rdata_q  <= mem[s_araddr[9:2]];
            ar_hs_cnt   <= ar_hs_cnt + 1;
        end else if (s_rready && sl_rvalid_q) begin
            sl_rvalid_q <= 1'b0;
        end
        aw_now = sl_aw_got | s_awvalid;
        w_now  = sl_w_got | s_wvalid;
        idx    = s_awvalid ? s_awaddr[9:2] : sl_awidx;
        wd     = s_wvalid ? s_wdata : sl_wdata;
        ws     = s_wvalid ? s_wstrb : sl_wstrb;
        sl_bvalid_q <= 1'b0;
        if (aw_now && w_now) begin
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
            end
            sl_bvalid_q <= 1'b1;
            sl_aw_got   <= 1'b0;
            sl_w_got    <= 1'b0;
        end else begin
            if (s_awvalid) begin
                sl_aw_got <= 1'b1;
                sl_awidx  <= s_awaddr[9:2];
            end
            if (s_wvalid) begin
                sl_w_got <= 1'b1;
                sl_wdata <= s_wdata;
                sl_wstrb <= s_wstrb;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after input changes
    task automatic settle();
        #1;
    endtask

    // One contended read round starting in IDLE; exp is the master that should win
    task automatic round(input logic exp);
        logic [1:0] want;
        want = exp ? 2'b10 : 2'b01;
        settle();
        check("t3_arb_no_arready", 32'({m1_arready, m0_arready}), 32'd0);
        tick(); settle();
        check("t3_arready_grant", 32'({m1_arready, m0_arready}), 32'(want));
        tick(); settle();
        check("t3_rvalid_owner", 32'({m1_rvalid, m0_rvalid}), 32'(want));
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 32'h0000_0413;

        // Reset: requests are ignored, every output is 0
        tick(); tick();
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        settle();
        check("reset_outputs_zero", 32'(any_out), 32'd0);
        check("reset_state_idle", 32'(dut.state_q), 32'(IDLE));
        tick();
        rst = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;

        // 1: single read by m0
        tick();
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
        settle();
        check("t1_arb_cycle_s_arvalid", 32'(s_arvalid), 32'd0);
        tick(); settle();
        check("t1_s_arvalid", 32'(s_arvalid), 32'd1);
        check("t1_s_araddr", s_araddr, 32'h8000_0000);
        check("t1_m0_arready", 32'(m0_arready), 32'd1);
        check("t1_m1_arready", 32'(m1_arready), 32'd0);
        tick();
        m0_arvalid = 1'b0; m0_rready = 1'b1;
        settle();
        check("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("t1_m0_rdata", m0_rdata, 32'h0000_0413);
        tick();
        m0_rready = 1'b0;
        settle();
        check("t1_back_idle", 32'(dut.state_q), 32'(IDLE));
        check("t1_m0_rvalid_low", 32'(m0_rvalid), 32'd0);

        // 2: single write by m1, then read it back
        m1_awaddr = 32'h8000_0100; m1_awvalid = 1'b1;
        m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0011; m1_wvalid = 1'b1; m1_bready = 1'b1;
        settle();
        check("t2_arb_cycle_s_awvalid", 32'(s_awvalid), 32'd0);
        tick(); settle();
        check("t2_s_aw_w_valid", 32'({s_awvalid, s_wvalid}), 32'd3);
        check("t2_s_wstrb", 32'(s_wstrb), 32'd3);
        check("t2_m1_aw_w_ready", 32'({m1_awready, m1_wready}), 32'd3);
        check("t2_m0_awready", 32'(m0_awready), 32'd0);
        tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        settle();
        check("t2_m1_bvalid", 32'(m1_bvalid), 32'd1);
        check("t2_no_dup_aw_w", 32'({s_awvalid, s_wvalid}), 32'd0);
        tick(); settle();
        check("t2_m1_bvalid_pulse", 32'(m1_bvalid), 32'd0);
        check("t2_back_idle", 32'(dut.state_q), 32'(IDLE));
        m1_bready = 1'b0;
        m1_araddr = 32'h8000_0100; m1_arvalid = 1'b1;
        tick(); tick();
        m1_arvalid = 1'b0; m1_rready = 1'b1;
        settle();
        check("t2_readback_rvalid", 32'(m1_rvalid), 32'd1);
        check("t2_readback_rdata", m1_rdata, 32'h0000_BEEF);
        tick();
        m1_rready = 1'b0;

        // 3: contention from reset alternates 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_araddr = 32'h8000_0000; m1_araddr = 32'h8000_0100;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1;
        round(1'b0);
        round(1'b1);
        round(1'b0);
        round(1'b1);
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; m1_rready = 1'b0;

        // Plain m0 read so that last = 0
        m0_arvalid = 1'b1;
        tick(); tick();
        m0_arvalid = 1'b0;
        settle();
        check("t4_prep_m0_rvalid", 32'(m0_rvalid), 32'd1);
        tick();

        // 4: m0 read and m1 write together; m1 wins because m0 went last
        m0_arvalid = 1'b1;
        m1_awaddr = 32'h8000_0104; m1_awvalid = 1'b1;
        m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF; m1_wvalid = 1'b1; m1_bready = 1'b1;
        tick(); settle();
        check("t4_wr_first_readies", 32'({m1_awready, m1_wready, m0_arready}), 32'd6);
        check("t4_s_arvalid_low", 32'(s_arvalid), 32'd0);
        tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        settle();
        check("t4_bvalid_routing", 32'({m1_bvalid, m0_bvalid}), 32'd2);
        check("t4_rvalid_none", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        tick(); settle();
        check("t4_idle_m0_arready", 32'(m0_arready), 32'd0);
        tick(); settle();
        check("t4_m0_arready", 32'(m0_arready), 32'd1);
        check("t4_s_araddr", s_araddr, 32'h8000_0000);
        tick();
        m0_arvalid = 1'b0;
        settle();
        check("t4_rvalid_routing", 32'({m1_rvalid, m0_rvalid}), 32'd1);
        check("t4_m0_rdata", m0_rdata, 32'h0000_0413);
        check("t4_bvalid_none", 32'({m1_bvalid, m0_bvalid}), 32'd0);
        tick();
        m0_rready = 1'b0;

        // 5: m1 presents read and write together, read served first
        ar_base = ar_hs_cnt;
        m1_araddr = 32'h8000_0104; m1_arvalid = 1'b1;
        m1_awaddr = 32'h8000_0108; m1_awvalid = 1'b1;
        m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF; m1_wvalid = 1'b1;
        tick(); settle();
        check("t5_read_first", 32'({s_arvalid, s_awvalid, s_wvalid}), 32'd4);
        check("t5_m1_awready", 32'(m1_awready), 32'd0);
        tick();
        m1_rready = 1'b1;
        settle();
        check("t5_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("t5_m1_rdata", m1_rdata, 32'h1234_5678);
        check("t5_no_dup_ar", 32'(s_arvalid), 32'd0);
        m1_arvalid = 1'b0;
        tick();
        m1_rready = 1'b0;
        settle();
        check("t5_idle_between", 32'(dut.state_q), 32'(IDLE));
        tick(); settle();
        check("t5_then_write", 32'({s_awvalid, s_wvalid}), 32'd3);
        tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        settle();
        check("t5_m1_bvalid", 32'(m1_bvalid), 32'd1);
        tick();
        check("t5_single_ar_handshake", 32'(ar_hs_cnt - ar_base), 32'd1);
        m1_bready = 1'b0;

        // 6: reset after the ar handshake, before rready
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b0;
        tick(); settle();
        check("t6_m0_arready", 32'(m0_arready), 32'd1);
        tick();
        m0_arvalid = 1'b0;
        settle();
        check("t6_pending_rvalid", 32'(m0_rvalid), 32'd1);
        rst = 1'b1;
        settle();
        check("t6_reset_cycle_outputs", 32'(any_out), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("t6_state_idle", 32'(dut.state_q), 32'(IDLE));
        check("t6_stale_rvalid_masked", 32'(m0_rvalid), 32'd0);
        check("t6_idle_outputs", 32'(any_out), 32'd0);
        m0_arvalid = 1'b1;
        settle();
        check("t6_arb_cycle_s_arvalid", 32'(s_arvalid), 32'd0);
        tick(); settle();
        check("t6_regrant", 32'({s_arvalid, m0_arready}), 32'd3);
        tick();
        m0_arvalid = 1'b0; m0_rready = 1'b1;
        settle();
        check("t6_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("t6_m0_rdata", m0_rdata, 32'h0000_0413);
        tick();
        m0_rready = 1'b0;
        settle();
        check("t6_final_idle", 32'(dut.state_q), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter2.md
Name: axi_lite_arbiter2

Overview:
- Two-master to one-slave AXI-lite arbiter placed directly upstream of the data memory slave.
- Master 0 is the instruction fetch unit. Master 1 is the load/store unit.
- The slave side drives the shared memory slave, which has always-ready ar/aw/w channels, 1-bit resp fields and a DPI-backed array.
- Only one transaction is in flight at a time. The granted master owns the slave until its response handshake completes.

Parameters:
- ADDR_W, 32, address width on all ar/aw channels.
- DATA_W, 32, data width. The strobe width is DATA_W/8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- m{0,1}_araddr / m{0,1}_arvalid  in  ADDR_W / 1  read address channel from master 0/1.
- m{0,1}_arready  out  1  read address accept to master 0/1.
- m{0,1}_rdata / m{0,1}_rresp / m{0,1}_rvalid  out  DATA_W / 1 / 1  read data channel to master 0/1.
- m{0,1}_rready  in  1  read data accept from master 0/1.
- m{0,1}_awaddr / m{0,1}_awvalid  in  ADDR_W / 1  write address channel from master 0/1.
- m{0,1}_awready  out  1  write address accept to master 0/1.
- m{0,1}_wdata / m{0,1}_wstrb / m{0,1}_wvalid  in  DATA_W / DATA_W/8 / 1  write data channel from master 0/1.
- m{0,1}_wready  out  1  write data accept to master 0/1.
- m{0,1}_bresp / m{0,1}_bvalid  out  1 / 1  write response to master 0/1.
- m{0,1}_bready  in  1  write response accept from master 0/1.
- s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready  out  as above  slave-side request signals.
- s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid  in  as above  slave-side response signals.

Behaviour:
- Request per master: req_i = m_i_arvalid | m_i_awvalid | m_i_wvalid.
- States: IDLE, RD (read owned by `owner`), WR (write owned by `owner`).
- Registers: `owner` (1b), `last` (1b, last-granted master), `ar_done`, `aw_done`, `w_done`.
- IDLE:
  - No s_*valid asserted.
  - All m_*ready and m_*valid outputs are 0.
  - When a request exists, pick the winner round-robin: if both masters request, take the master != last; otherwise take the sole requester.
  - Winner with arvalid goes to RD. Otherwise it goes to WR; a simultaneous read and write from one master is served read first.
  - Set owner and last; clear the done flags.
  - Arbitration adds exactly 1 cycle before forwarding starts.
- RD:
  - s_araddr = owner araddr.
  - s_arvalid = owner arvalid & ~ar_done.
  - owner arready = s_arready & ~ar_done.
  - Set ar_done on the ar handshake.
  - s_rvalid, rdata and rresp are routed to the owner. s_rready = owner rready.
  - On s_rvalid & s_rready, return to IDLE in the next cycle.
- WR:
  - aw and w channels are forwarded independently, each masked by its done flag, in the same way as ar.
  - Both handshakes may happen in the same cycle.
  - b channel routed to the owner. s_bready = owner bready.
  - On s_bvalid & s_bready, return to IDLE.
  - The slave pulses bvalid for a single cycle, so masters must hold bready high while a write is outstanding.
- The non-owner always sees arready, awready, wready, rvalid and bvalid = 0. Its data outputs are 0.
- Pass-through in RD/WR is combinational: zero added latency per channel beyond the arbitration cycle.
- Back-to-back: after completion, IDLE evaluates the next cycle. With both masters continuously requesting, grants alternate 0,1,0,1.
- Reset (any state, including mid-transaction):
  - State goes to IDLE, owner=0, last=1 (so master 0 wins the first tie), done flags = 0.
  - All outputs are 0 in the reset cycle and in IDLE.
  - An abandoned slave response after reset is ignored because IDLE masks s_rvalid/s_bvalid.

Decomposition:
- Shared package `axi_lite_pkg`:
  - state enum {IDLE, RD, WR}.
  - master-id constants M_IFU=0, M_LSU=1.
  - RESP_OKAY=1'b0.
- One sub-module, `rr_arb2`:
  - Inputs: req[1:0], last, en.
  - Outputs: grant id and valid.
  - Combinational, reused by later crossbars.
- The mux/mask logic stays in the top module.

Test Plan:
1. Single read: m0 reads 0x8000_0000 holding 0x0000_0413 → s_arvalid rises 1 cycle after m0_arvalid; m0_rdata=0x413 and m0_rvalid=1 one cycle after the ar handshake; FSM back in IDLE after rready.
2. Single write: m1 writes 0xDEADBEEF, wstrb=4'b0011, addr 0x8000_0100 → s_awvalid and s_wvalid asserted in the same cycle; m1_bvalid=1 for 1 cycle; a subsequent m1 read of that address returns 0x0000BEEF over the prior 0.
3. Contention: m0 and m1 both assert arvalid from reset → grant order m0, m1, m0, m1; the non-owner's arready stays 0 until its grant.
4. Mixed: m0 read and m1 write asserted together after last=0 → m1 write served first, then m0 read; each master sees only its own response.
5. Read-first rule: m1 asserts arvalid and awvalid together → RD completes, then WR; exactly one s_arvalid handshake, with no duplicate ar during RD.
6. Reset mid-RD: assert rst for 1 cycle after the ar handshake but before rready → all outputs 0, state IDLE; the next m0 request is granted normally.
